// File: rtl/fmcw_defines.sv
// Shared FMCW receive-chain defaults and the ADC capture controller state encoding.
package fmcw_defines;

    localparam int unsigned FMCW_DW         = 14;
    localparam int unsigned FMCW_CW         = 16;
    localparam int unsigned FMCW_SETTLE_DEF = 16;
    localparam int unsigned FMCW_FIR_TAPS   = 32;
    localparam int unsigned FMCW_DECIM      = 8;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_SETTLE  = 2'd2,
        CAP_CAPTURE = 2'd3
    } cap_state_t;

endpackage

// File: rtl/adc_out_reg.sv
// One-entry valid/ready output register carrying a sample and its frame markers.
module adc_out_reg #(
    parameter int unsigned DW = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          first_i,
    input  logic          last_i,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          first_o,
    output logic          last_o,
    output logic          full_o
);

    assign full_o = valid_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            first_o <= 1'b0;
            last_o  <= 1'b0;
        end else if (clr_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            first_o <= 1'b0;
            last_o  <= 1'b0;
        end else if (load_i) begin
            // a load in the same cycle as a consume simply replaces the entry
            data_o  <= data_i;
            valid_o <= 1'b1;
            first_o <= first_i;
            last_o  <= last_i;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
            first_o <= 1'b0;
            last_o  <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Per-chirp ADC capture sequencer: flush, settle discard, N-sample framed output.
// FMCW_ADC_CAPTURE_CONT_EN: re-arm after each frame instead of returning to idle.
module adc_capture_ctrl
    import fmcw_defines::*;
#(
    parameter int unsigned DW         = FMCW_DW,
    parameter int unsigned CW         = FMCW_CW,
    parameter int unsigned SETTLE_DEF = FMCW_SETTLE_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          arm_i,
    input  logic          abort_i,
    input  logic [CW-1:0] settle_i,
    input  logic [CW-1:0] nsamp_i,
    input  logic          chirp_i,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic          dp_ce_o,
    output logic          dp_flush_o,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          first_o,
    output logic          last_o,
    output logic          busy_o,
    output logic          ovf_o
);

`ifdef FMCW_ADC_CAPTURE_CONT_EN
    localparam cap_state_t FRAME_DONE_ST = CAP_ARMED;
`else
    localparam cap_state_t FRAME_DONE_ST = CAP_IDLE;
`endif

    cap_state_t    state;
    logic [CW-1:0] settle_cfg;
    logic [CW-1:0] nsamp_cfg;
    logic [CW-1:0] settle_cnt;
    logic [CW-1:0] samp_cnt;
    logic          out_full;
    logic          cap_load;
    logic          cap_first;
    logic          cap_last;
    logic          ovf_hit;

    always_comb begin
        cap_load  = 1'b0;
        ovf_hit   = 1'b0;
        cap_first = (samp_cnt == '0);
        cap_last  = (samp_cnt == nsamp_cfg - CW'(1));
        if (!abort_i && state == CAP_CAPTURE && valid_i) begin
            if (out_full && !ready_i)
                ovf_hit = 1'b1;
            else
                cap_load = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= CAP_IDLE;
            settle_cfg <= CW'(SETTLE_DEF);
            nsamp_cfg  <= '0;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            dp_ce_o    <= 1'b0;
            dp_flush_o <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            dp_flush_o <= 1'b0;
            if (abort_i) begin
                state   <= CAP_IDLE;
                dp_ce_o <= 1'b0;
            end else begin
                case (state)
                    CAP_IDLE: begin
                        if (arm_i && nsamp_i != '0) begin
                            settle_cfg <= settle_i;
                            nsamp_cfg  <= nsamp_i;
                            ovf_o      <= 1'b0;
                            state      <= CAP_ARMED;
                        end
                    end
                    CAP_ARMED: begin
                        if (chirp_i) begin
                            dp_flush_o <= 1'b1;
                            dp_ce_o    <= 1'b1;
                            settle_cnt <= '0;
                            samp_cnt   <= '0;
                            state      <= (settle_cfg == '0) ? CAP_CAPTURE : CAP_SETTLE;
                        end
                    end
                    CAP_SETTLE: begin
                        if (valid_i) begin
                            if (settle_cnt == settle_cfg - CW'(1))
                                state <= CAP_CAPTURE;
                            else
                                settle_cnt <= settle_cnt + CW'(1);
                        end
                    end
                    CAP_CAPTURE: begin
                        if (ovf_hit) begin
                            ovf_o   <= 1'b1;
                            dp_ce_o <= 1'b0;
                            state   <= CAP_IDLE;
                        end else if (cap_load) begin
                            if (cap_last) begin
                                dp_ce_o <= 1'b0;
                                state   <= FRAME_DONE_ST;
                            end else begin
                                samp_cnt <= samp_cnt + CW'(1);
                            end
                        end
                    end
                    default: state <= CAP_IDLE;
                endcase
            end
        end
    end

    assign busy_o = (state != CAP_IDLE) || out_full;

    adc_out_reg #(.DW(DW)) u_out_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (abort_i),
        .load_i  (cap_load),
        .data_i  (data_i),
        .first_i (cap_first),
        .last_i  (cap_last),
        .ready_i (ready_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .first_o (first_o),
        .last_o  (last_o),
        .full_o  (out_full)
    );

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: vector table plus multi-cycle corner sequences.
module tb_adc_capture_ctrl;

    localparam int unsigned DW = 14;
    localparam int unsigned CW = 16;

    typedef struct {
        logic [CW-1:0] settle;
        logic [CW-1:0] nsamp;
        int unsigned   nin;
        logic [DW-1:0] base;
        logic [DW-1:0] exp_first;
        int unsigned   exp_n;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          f;
        logic          l;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          arm;
    logic          abort_s;
    logic [CW-1:0] settle;
    logic [CW-1:0] nsamp;
    logic          chirp;
    logic [DW-1:0] din;
    logic          vin;
    logic          dp_ce;
    logic          dp_flush;
    logic [DW-1:0] dout;
    logic          vout;
    logic          ready;
    logic          first;
    logic          last;
    logic          busy;
    logic          ovf;

    int errors = 0;
    int checks = 0;
    beat_t sb[$];
    vec_t  vecs[4];

    adc_capture_ctrl #(.DW(DW), .CW(CW), .SETTLE_DEF(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .arm_i      (arm),
        .abort_i    (abort_s),
        .settle_i   (settle),
        .nsamp_i    (nsamp),
        .chirp_i    (chirp),
        .data_i     (din),
        .valid_i    (vin),
        .dp_ce_o    (dp_ce),
        .dp_flush_o (dp_flush),
        .data_o     (dout),
        .valid_o    (vout),
        .ready_i    (ready),
        .first_o    (first),
        .last_o     (last),
        .busy_o     (busy),
        .ovf_o      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every accepted output beat is matched against the queue head
    always @(negedge clk) begin
        if (!rst && vout && ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h first %0b last %0b expected none", dout, first, last);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_data",  32'(dout),  32'(e.d));
                check("beat_first", 32'(first), 32'(e.f));
                check("beat_last",  32'(last),  32'(e.l));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [CW-1:0] s, input logic [CW-1:0] n);
        arm = 1'b1; settle = s; nsamp = n;
        step();
        arm = 1'b0;
    endtask

    task automatic do_chirp(input logic exp_flush);
        chirp = 1'b1;
        step();
        chirp = 1'b0;
        check("chirp_flush", 32'(dp_flush), 32'(exp_flush));
    endtask

    task automatic send(input logic [DW-1:0] d, input int unsigned gap);
        din = d; vin = 1'b1;
        step();
        vin = 1'b0;
        for (int unsigned g = 0; g < gap; g++) step();
    endtask

    task automatic do_abort();
        abort_s = 1'b1;
        step();
        abort_s = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic f, input logic l);
        beat_t b;
        b.d = d; b.f = f; b.l = l;
        sb.push_back(b);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || vout) && n < 60) begin
            step();
            n++;
        end
        check("drain_done", 32'(sb.size() == 0 && !vout), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic cont;
`ifdef FMCW_ADC_CAPTURE_CONT_EN
        cont = 1'b1;
`else
        cont = 1'b0;
`endif
        rst = 1'b0; arm = 1'b0; abort_s = 1'b0; settle = '0; nsamp = '0;
        chirp = 1'b0; din = '0; vin = 1'b0; ready = 1'b1;

        vecs[0] = '{settle: 16'd3, nsamp: 16'd4, nin: 8, base: 14'h0001, exp_first: 14'h0004, exp_n: 4};
        vecs[1] = '{settle: 16'd0, nsamp: 16'd1, nin: 1, base: 14'h01AB, exp_first: 14'h01AB, exp_n: 1};
        vecs[2] = '{settle: 16'd2, nsamp: 16'd3, nin: 5, base: 14'h0100, exp_first: 14'h0102, exp_n: 3};
        vecs[3] = '{settle: 16'd1, nsamp: 16'd2, nin: 4, base: 14'h3FFE, exp_first: 14'h3FFF, exp_n: 2};

        #1 rst = 1'b1;
        #20;
        check("rst_valid", 32'(vout), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ce",    32'(dp_ce), 32'd0);
        check("rst_flush", 32'(dp_flush), 32'd0);
        check("rst_ovf",   32'(ovf), 32'd0);
        @(negedge clk) rst = 1'b0;
        step();

        for (int unsigned i = 0; i < 4; i++) begin
            do_arm(vecs[i].settle, vecs[i].nsamp);
            check("vec_armed_busy", 32'(busy), 32'd1);
            check("vec_armed_ce", 32'(dp_ce), 32'd0);
            for (int unsigned j = 0; j < vecs[i].exp_n; j++) begin
                d = vecs[i].exp_first + DW'(j);
                push(d, j == 0, j == vecs[i].exp_n - 1);
            end
            do_chirp(1'b1);
            check("vec_ce_on", 32'(dp_ce), 32'd1);
            for (int unsigned k = 0; k < vecs[i].nin; k++) begin
                d = vecs[i].base + DW'(k);
                send(d, 1);
                if (k == 0) check("vec_flush_one_cycle", 32'(dp_flush), 32'd0);
            end
            drain();
            check("vec_ce_off", 32'(dp_ce), 32'd0);
            check("vec_busy_end", 32'(busy), 32'(cont));
            check("vec_ovf", 32'(ovf), 32'd0);
            if (cont) do_abort();
        end

        // overflow: ready drops after the first beat, samples every 4 cycles
        do_arm(16'd0, 16'd4);
        do_chirp(1'b1);
        push(14'h0011, 1'b1, 1'b0);
        push(14'h0022, 1'b0, 1'b0);
        send(14'h0011, 0);
        check("ovf_first_valid", 32'(vout), 32'd1);
        step();
        ready = 1'b0;
        step(); step();
        send(14'h0022, 3);
        send(14'h0033, 0);
        check("ovf_flag", 32'(ovf), 32'd1);
        check("ovf_ce_idle", 32'(dp_ce), 32'd0);
        step(); step();
        check("ovf_hold_valid", 32'(vout), 32'd1);
        check("ovf_hold_data", 32'(dout), 32'h0022);
        check("ovf_no_last", 32'(last), 32'd0);
        check("ovf_busy_full", 32'(busy), 32'd1);
        ready = 1'b1;
        drain();
        check("ovf_busy_drained", 32'(busy), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'd1);
        do_arm(16'd0, 16'd2);
        check("ovf_cleared_by_arm", 32'(ovf), 32'd0);
        do_abort();
        check("abort_idle_busy", 32'(busy), 32'd0);

        // abort during settle
        do_arm(16'd5, 16'd2);
        do_chirp(1'b1);
        send(14'h0101, 1);
        send(14'h0102, 1);
        do_abort();
        check("abort_settle_ce", 32'(dp_ce), 32'd0);
        check("abort_settle_busy", 32'(busy), 32'd0);
        do_chirp(1'b0);
        send(14'h0103, 2);

        // abort during capture with a beat pending
        do_arm(16'd0, 16'd3);
        do_chirp(1'b1);
        ready = 1'b0;
        send(14'h0055, 0);
        check("abort_cap_pending", 32'(vout), 32'd1);
        do_abort();
        check("abort_cap_valid", 32'(vout), 32'd0);
        check("abort_cap_ce", 32'(dp_ce), 32'd0);
        check("abort_cap_busy", 32'(busy), 32'd0);
        ready = 1'b1;
        do_chirp(1'b0);
        send(14'h0056, 2);
        check("abort_cap_no_out", 32'(vout), 32'd0);

        // rejected arm and idle chirp
        do_arm(16'd2, 16'd0);
        check("arm_zero_busy", 32'(busy), 32'd0);
        do_chirp(1'b0);
        check("idle_chirp_ce", 32'(dp_ce), 32'd0);
        check("idle_chirp_busy", 32'(busy), 32'd0);

        // async reset in the middle of a frame
        do_arm(16'd0, 16'd3);
        do_chirp(1'b1);
        ready = 1'b0;
        send(14'h0077, 0);
        check("mid_rst_pending", 32'(vout), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(vout), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ce", 32'(dp_ce), 32'd0);
        @(negedge clk) rst = 1'b0;
        ready = 1'b1;
        step();

        // repeated chirps after a single arm
        do_arm(16'd1, 16'd2);
        for (int unsigned c = 0; c < 3; c++) begin
            logic on;
            on = cont || (c == 0);
            d = DW'(c * 16);
            if (on) begin
                push(d + DW'(1), 1'b1, 1'b0);
                push(d + DW'(2), 1'b0, 1'b1);
            end
            do_chirp(on);
            send(d, 1);
            send(d + DW'(1), 1);
            send(d + DW'(2), 1);
            drain();
        end
        check("multi_busy_end", 32'(busy), 32'(cont));
        do_abort();
        check("multi_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Sequences the ADC receive datapath (FIR + downsample) for each FMCW chirp. On a chirp trigger it flushes the datapath, discards a settling window of decimated samples, then forwards exactly N samples as a framed stream with start/last markers and valid/ready handshake. It sits between the downsample output and the sample FIFO/FFT input, and is the only block that drives the datapath enable and flush controls.

Parameters:
DW, 14, sample width (matches datapath output width OW)
CW, 16, width of settle and sample counters
SETTLE_DEF, 16, settle count loaded while idle if settle_i is not driven (reset value of config register)

Ports:
clk_i  in  1  datapath clock; single clock domain
rst_i  in  1  asynchronous, active-high reset
arm_i  in  1  pulse: latch settle_i/nsamp_i, IDLE->ARMED
abort_i  in  1  pulse: return to IDLE from any state
settle_i  in  CW  decimated samples to discard after trigger
nsamp_i  in  CW  samples per frame; 0 = arm rejected
chirp_i  in  1  chirp-start pulse from ramp generator
data_i  in  DW  decimated sample from downsample
valid_i  in  1  data_i valid (one cycle per decimated sample)
dp_ce_o  out  1  datapath clock enable
dp_flush_o  out  1  one-cycle datapath reset/flush
data_o  out  DW  framed sample
valid_o  out  1  data_o valid
ready_i  in  1  downstream accepts when valid_o&&ready_i
first_o  out  1  qualifies first sample of frame
last_o  out  1  qualifies final sample of frame
busy_o  out  1  state != IDLE or output register full
ovf_o  out  1  sticky overflow; cleared by arm_i

Behaviour:
- Reset: state IDLE; all outputs 0; config registers settle=SETTLE_DEF, nsamp=0; counters 0.
- States: IDLE, ARMED, SETTLE, CAPTURE.
- IDLE: arm_i && nsamp_i!=0 -> latch config, clear ovf_o, ARMED. arm_i with nsamp_i==0 ignored.
- ARMED: dp_ce_o=0. chirp_i -> dp_flush_o=1 for that cycle, counters cleared, -> SETTLE (or CAPTURE if settle==0).
- SETTLE: dp_ce_o=1; each valid_i increments settle counter, sample discarded; on settle-th sample -> CAPTURE.
- CAPTURE: dp_ce_o=1; each valid_i loads one-entry output register; data_o/valid_o registered, latency 1 cycle from valid_i. first_o on sample index 0, last_o on index nsamp-1; after loading last -> IDLE (output register drains independently).
- nsamp==1: first_o and last_o asserted together.
- Output register holds data and flags stable until valid_o&&ready_i.
- Overflow: valid_i in CAPTURE while register full and not being consumed that cycle -> sample dropped, ovf_o=1, frame aborted (-> IDLE, no last_o). Consume and load in the same cycle is legal, no overflow.
- chirp_i outside ARMED ignored. arm_i outside IDLE ignored.
- abort_i: highest priority; -> IDLE, dp_ce_o=0, output register cleared (valid_o=0) next cycle; ovf_o retained.
- Async reset mid-frame: immediate return to reset values.

Optional Feature:
Macro FMCW_ADC_CAPTURE_CONT_EN. Defined: after last sample loaded, state -> ARMED (not IDLE) with the same latched config, so every subsequent chirp_i captures a frame until abort_i; overflow still aborts to IDLE. Undefined: single-shot, one frame per arm_i.

Decomposition:
- Shared package fmcw_defines: state encoding constants, DW/CW defaults alongside existing FMCW default parameters.
- Sub-module adc_out_reg: one-entry valid/ready output register carrying {data, first, last} with a full flag and clear input; controller FSM and counters stay in adc_capture_ctrl.

Test Plan:
- arm settle=3 nsamp=4, chirp, 8 valid_i samples 1..8, ready_i=1 -> flush pulse on chirp cycle; output 4,5,6,7 with first_o on 4, last_o on 7; sample 8 ignored; busy_o low after drain.
- settle=0 nsamp=1, chirp, sample 0x1AB -> single beat 0x1AB with first_o=last_o=1.
- nsamp=4, ready_i=0 from 2nd sample on, valid_i every 4 cycles -> first sample accepted, 3rd sample overflows: ovf_o=1, state IDLE, no last_o; next arm_i clears ovf_o.
- abort_i in SETTLE and in CAPTURE with valid_o pending -> IDLE next cycle, valid_o=0, dp_ce_o=0; chirp_i afterwards produces nothing.
- arm_i with nsamp_i=0, and chirp_i while IDLE -> no state change, no dp_flush_o.
- With FMCW_ADC_CAPTURE_CONT_EN: arm once, 3 chirps, nsamp=2 -> three 2-sample frames, each flushed; without macro only first frame.
